mmio_router: RTL and testbench

- Sits between the core's uncached MMIO load/store port and the peripheral slots (ACLINT timer, SysCon power/reboot, future UART).
- Decodes word addresses to one of NUM_SLOTS peripherals and forwards reads and writes with registered request signals.
- Tracks one outstanding read, returns its data or an error, and times out silent or unmapped targets.

---
 rtl/mmio_router_pkg.sv | 17 +
 rtl/mmio_addr_decode.sv | 31 +++
 rtl/mmio_router.sv | 178 +++++++++++++++++
 tb/tb_mmio_router.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_router_pkg.sv
// Shared definitions for the MMIO router: read FSM state encoding and the default slot map.
package mmio_router_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [31:0] MTIME_ADDR    = 32'hFF000000;
    localparam logic [31:0] MTIMECMP_ADDR = 32'hFF000008;
    localparam logic [31:0] SYSCON_ADDR   = 32'h11000000;

    // Slot 0 is the leftmost (most significant) 32-bit entry of each table.
    localparam logic [63:0] DEF_SLOT_BASE = {MTIME_ADDR, SYSCON_ADDR};
    localparam logic [63:0] DEF_SLOT_MASK = {32'hFFFFFFF0, 32'hFFFF0000};

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational priority decoder: word address -> hit flag and lowest-index matching slot.
module mmio_addr_decode
    import mmio_router_pkg::*;
#(
    parameter int unsigned                   NUM_SLOTS = 2,
    parameter int unsigned                   SLOT_W    = 1,
    parameter logic [NUM_SLOTS*32-1:0]       SLOT_BASE = DEF_SLOT_BASE,
    parameter logic [NUM_SLOTS*32-1:0]       SLOT_MASK = DEF_SLOT_MASK
) (
    input  logic [29:0]       i_addr,
    output logic              o_hit,
    output logic [SLOT_W-1:0] o_slot
);

    logic [31:0] w_byte_addr;
    assign w_byte_addr = {i_addr, 2'b00};

    // Scan from the highest index down so the lowest matching slot is the last writer.
    always_comb begin
        o_hit  = 1'b0;
        o_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if ((w_byte_addr & SLOT_MASK[(NUM_SLOTS-1-i)*32 +: 32]) ==
                (SLOT_BASE[(NUM_SLOTS-1-i)*32 +: 32] & SLOT_MASK[(NUM_SLOTS-1-i)*32 +: 32])) begin
                o_hit  = 1'b1;
                o_slot = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_router.sv
// Routes uncached MMIO loads/stores to peripheral slots; one outstanding read at a time.
// Optional read timeout enabled by defining MMIO_ROUTER_TIMEOUT_EN.
module mmio_router
    import mmio_router_pkg::*;
#(
    parameter int unsigned             NUM_SLOTS = 2,
    parameter logic [NUM_SLOTS*32-1:0] SLOT_BASE = DEF_SLOT_BASE,
    parameter logic [NUM_SLOTS*32-1:0] SLOT_MASK = DEF_SLOT_MASK,
    parameter int unsigned             TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IN_re,
    input  logic [29:0]             IN_raddr,
    output logic                    OUT_rbusy,
    output logic [31:0]             OUT_rdata,
    output logic                    OUT_rvalid,
    output logic                    OUT_rerr,
    input  logic                    IN_we,
    input  logic [3:0]              IN_wmask,
    input  logic [29:0]             IN_waddr,
    input  logic [31:0]             IN_wdata,
    output logic                    OUT_werr,
    output logic [NUM_SLOTS-1:0]    OUT_pRe,
    output logic [29:0]             OUT_pRaddr,
    input  logic [NUM_SLOTS*32-1:0] IN_pRdata,
    input  logic [NUM_SLOTS-1:0]    IN_pRbusy,
    input  logic [NUM_SLOTS-1:0]    IN_pRvalid,
    output logic [NUM_SLOTS-1:0]    OUT_pWe,
    output logic [3:0]              OUT_pWmask,
    output logic [29:0]             OUT_pWaddr,
    output logic [31:0]             OUT_pWdata
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                 w_rhit, w_whit;
    logic [SLOT_W-1:0]    w_rslot, w_wslot;
    logic [NUM_SLOTS-1:0] w_sel;
    logic                 w_sel_busy, w_sel_valid;
    logic [31:0]          w_sel_data;

    logic [1:0]           r_state;
    logic [29:0]          r_raddr;
    logic [SLOT_W-1:0]    r_rslot;
    logic [31:0]          r_rdata;
    logic                 r_rerr;
    logic [NUM_SLOTS-1:0] r_pwe;
    logic [3:0]           r_wmask;
    logic [29:0]          r_waddr;
    logic [31:0]          r_wdata;
    logic                 r_werr;

`ifdef MMIO_ROUTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
`endif

    mmio_addr_decode #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK)
    ) u_rd_decode (
        .i_addr (IN_raddr),
        .o_hit  (w_rhit),
        .o_slot (w_rslot)
    );

    mmio_addr_decode #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK)
    ) u_wr_decode (
        .i_addr (IN_waddr),
        .o_hit  (w_whit),
        .o_slot (w_wslot)
    );

    // Only the latched slot's handshake is observed; other slots are ignored.
    assign w_sel       = NUM_SLOTS'(1) << r_rslot;
    assign w_sel_busy  = |(IN_pRbusy & w_sel);
    assign w_sel_valid = |(IN_pRvalid & w_sel);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_rslot == SLOT_W'(i)) w_sel_data = IN_pRdata[i*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_raddr <= '0;
            r_rslot <= '0;
            r_rdata <= '0;
            r_rerr  <= 1'b0;
`ifdef MMIO_ROUTER_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (IN_re) begin
                        if (w_rhit) begin
                            r_raddr <= IN_raddr;
                            r_rslot <= w_rslot;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_rdata <= '0;
                            r_rerr  <= 1'b1;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!w_sel_busy) begin
                        r_state <= ST_WAIT;
`ifdef MMIO_ROUTER_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (w_sel_valid) begin
                        r_rdata <= w_sel_data;
                        r_rerr  <= 1'b0;
                        r_state <= ST_RESP;
                    end
`ifdef MMIO_ROUTER_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rdata <= '0;
                        r_rerr  <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwe   <= '0;
            r_werr  <= 1'b0;
            r_wmask <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_pwe  <= (IN_we && w_whit) ? (NUM_SLOTS'(1) << w_wslot) : '0;
            r_werr <= IN_we && !w_whit;
            if (IN_we) begin
                r_wmask <= IN_wmask;
                r_waddr <= IN_waddr;
                r_wdata <= IN_wdata;
            end
        end
    end

    assign OUT_rbusy  = (r_state != ST_IDLE);
    assign OUT_rvalid = (r_state == ST_RESP);
    assign OUT_rdata  = r_rdata;
    assign OUT_rerr   = r_rerr;
    assign OUT_pRe    = (r_state == ST_ISSUE) ? w_sel : '0;
    assign OUT_pRaddr = r_raddr;
    assign OUT_pWe    = r_pwe;
    assign OUT_werr   = r_werr;
    assign OUT_pWmask = r_wmask;
    assign OUT_pWaddr = r_waddr;
    assign OUT_pWdata = r_wdata;

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: table-driven reads/writes, scoreboard on responses.
module tb_mmio_router;

    localparam int NS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              IN_re, IN_we;
    logic [29:0]       IN_raddr, IN_waddr;
    logic [3:0]        IN_wmask;
    logic [31:0]       IN_wdata;
    logic              OUT_rbusy, OUT_rvalid, OUT_rerr, OUT_werr;
    logic [31:0]       OUT_rdata, OUT_pWdata;
    logic [NS-1:0]     OUT_pRe, OUT_pWe;
    logic [29:0]       OUT_pRaddr, OUT_pWaddr;
    logic [3:0]        OUT_pWmask;
    logic [NS*32-1:0]  IN_pRdata;
    logic [NS-1:0]     IN_pRbusy, IN_pRvalid;

    logic [NS-1:0]     pv_model = '0, pb_model = '0, pv_inj = '0;
    logic [NS*32-1:0]  pd_model = '0, pd_inj = '0;

    assign IN_pRvalid = pv_model | pv_inj;
    assign IN_pRbusy  = pb_model;
    assign IN_pRdata  = pd_model | pd_inj;

    always #5 clk = ~clk;

    mmio_router dut (
        .clk        (clk),
        .rst        (rst),
        .IN_re      (IN_re),
        .IN_raddr   (IN_raddr),
        .OUT_rbusy  (OUT_rbusy),
        .OUT_rdata  (OUT_rdata),
        .OUT_rvalid (OUT_rvalid),
        .OUT_rerr   (OUT_rerr),
        .IN_we      (IN_we),
        .IN_wmask   (IN_wmask),
        .IN_waddr   (IN_waddr),
        .IN_wdata   (IN_wdata),
        .OUT_werr   (OUT_werr),
        .OUT_pRe    (OUT_pRe),
        .OUT_pRaddr (OUT_pRaddr),
        .IN_pRdata  (IN_pRdata),
        .IN_pRbusy  (IN_pRbusy),
        .IN_pRvalid (IN_pRvalid),
        .OUT_pWe    (OUT_pWe),
        .OUT_pWmask (OUT_pWmask),
        .OUT_pWaddr (OUT_pWaddr),
        .OUT_pWdata (OUT_pWdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Peripheral model: cfg_busy busy cycles per issue, then valid cfg_delay cycles later.
    int          cfg_busy  [NS];
    int          cfg_delay [NS];
    logic [31:0] cfg_data  [NS];
    bit          cfg_resp  [NS];
    int          busy_used [NS];
    int          pend      [NS];

    initial begin
        for (int s = 0; s < NS; s++) begin
            cfg_busy[s] = 0; cfg_delay[s] = 1; cfg_data[s] = '0; cfg_resp[s] = 1'b0;
            busy_used[s] = 0; pend[s] = 0;
        end
    end

    always @(negedge clk) begin
        for (int s = 0; s < NS; s++) begin
            pv_model[s] = 1'b0;
            pd_model[s*32 +: 32] = '0;
            pb_model[s] = 1'b0;
            if (pend[s] > 0) begin
                pend[s]--;
                if (pend[s] == 0) begin
                    pv_model[s] = 1'b1;
                    pd_model[s*32 +: 32] = cfg_data[s];
                end
            end
            if (OUT_pRe[s]) begin
                if (busy_used[s] < cfg_busy[s]) begin
                    pb_model[s] = 1'b1;
                    busy_used[s]++;
                end else begin
                    busy_used[s] = 0;
                    if (cfg_resp[s]) pend[s] = cfg_delay[s];
                end
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (OUT_rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid actual rvalid=1 rdata %0h required no response (cycle %0d)",
                         OUT_rdata, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_rdata", OUT_rdata, e.data);
                chk("rsp_rerr", OUT_rerr, e.err);
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        int          slot;
        int          busy;
        int          delay;
        logic [31:0] data;
        logic [31:0] exp_data;
        bit          exp_err;
        bit          resp;
        int          lat;
        int          exp_pre;
    } rd_t;

    typedef struct {
        logic [31:0]   addr;
        logic [3:0]    mask;
        logic [31:0]   data;
        logic [NS-1:0] exp_pwe;
        logic          exp_err;
    } wr_t;

    rd_t rd [8];
    wr_t wr [5];

    // Call just after a negedge: drives the request this cycle and follows it to the response.
    task automatic run_read(input rd_t v);
        exp_t          e;
        int            busy_cnt = 0;
        int            pre_any  = 0;
        int            pre_ok   = 0;
        bit            done     = 1'b0;
        logic [NS-1:0] oh;
        oh = NS'(1) << v.slot;
        if (v.hit) begin
            cfg_busy[v.slot]  = v.busy;
            cfg_delay[v.slot] = v.delay;
            cfg_data[v.slot]  = v.data;
            cfg_resp[v.slot]  = v.resp;
        end
        IN_re    = 1'b1;
        IN_raddr = v.addr[31:2];
        e.data = v.exp_data;
        e.err  = v.exp_err;
        e.cyc  = cyc + v.lat;
        sb.push_back(e);
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            #1;
            IN_re = 1'b0;
            if (OUT_rbusy) busy_cnt++;
            if (OUT_pRe != '0) pre_any++;
            if (OUT_pRe == oh && OUT_pRaddr == v.addr[31:2]) pre_ok++;
            if (sb.size() == 0) done = 1'b1;
        end
        chk("read_done", 64'(done), 64'd1);
        chk("rbusy_cycles", 64'(busy_cnt), 64'(v.lat));
        chk("pre_cycles", 64'(pre_any), 64'(v.exp_pre));
        chk("pre_slot_addr", 64'(pre_ok), 64'(v.exp_pre));
    endtask

    initial begin
        rd_t v;
        int  cnt;
        #200000;
        $display("FAIL watchdog actual no finish required finish by 200000ns");
        $fatal(1);
    end

    initial begin
        rd_t v;
        int  cnt;
        rd[0] = '{32'hFF000000, 1, 0, 0, 1, 32'h00001234, 32'h00001234, 0, 1, 3, 1};
        rd[1] = '{32'h20000000, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0};
        rd[2] = '{32'h11000040, 1, 1, 3, 1, 32'hA5A50001, 32'hA5A50001, 0, 1, 6, 4};
        rd[3] = '{32'hFF00000C, 1, 0, 0, 4, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 6, 1};
        rd[4] = '{32'hFF000010, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0};
        rd[5] = '{32'h1100FFFC, 1, 1, 1, 2, 32'h0000FFFF, 32'h0000FFFF, 0, 1, 5, 2};
        rd[6] = '{32'h11010000, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0};
        rd[7] = '{32'h11000000, 1, 1, 0, 1, 32'h00005A5A, 32'h00005A5A, 0, 1, 3, 1};

        wr[0] = '{32'hFF000004, 4'b0001, 32'h00000055, 2'b01, 1'b0};
        wr[1] = '{32'h1100FFFC, 4'b1111, 32'hCAFEF00D, 2'b10, 1'b0};
        wr[2] = '{32'h20000000, 4'b0011, 32'h00000001, 2'b00, 1'b1};
        wr[3] = '{32'hFF00000C, 4'b1100, 32'h12345678, 2'b01, 1'b0};
        wr[4] = '{32'h11010000, 4'b1111, 32'h00000000, 2'b00, 1'b1};

        rst = 1'b1; IN_re = 1'b0; IN_raddr = '0; IN_we = 1'b0;
        IN_waddr = '0; IN_wmask = '0; IN_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", {OUT_rbusy, OUT_rvalid, OUT_rerr, OUT_werr, OUT_pRe, OUT_pWe}, 64'd0);
        chk("rst_data", {OUT_rdata, OUT_pWdata}, 64'd0);
        chk("rst_addr", {OUT_pRaddr, OUT_pWaddr, OUT_pWmask}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            run_read(rd[i]);
        end

        // Back-to-back writes: each cycle checks the previous cycle's write.
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk); #1;
            if (i > 0) begin
                chk("wr_pwe", OUT_pWe, wr[i-1].exp_pwe);
                chk("wr_werr", OUT_werr, wr[i-1].exp_err);
                if (wr[i-1].exp_pwe != '0)
                    chk("wr_fields", {OUT_pWmask, OUT_pWaddr, OUT_pWdata},
                        {wr[i-1].mask, wr[i-1].addr[31:2], wr[i-1].data});
            end
            if (i < 5) begin
                IN_we = 1'b1; IN_waddr = wr[i].addr[31:2];
                IN_wmask = wr[i].mask; IN_wdata = wr[i].data;
            end else begin
                IN_we = 1'b0;
            end
        end
        @(negedge clk); #1;
        chk("wr_idle", {OUT_pWe, OUT_werr}, 64'd0);

        // Write to slot 0 in the same cycle as a read to slot 1.
        @(negedge clk); #1;
        IN_we = 1'b1; IN_waddr = wr[0].addr[31:2]; IN_wmask = wr[0].mask; IN_wdata = wr[0].data;
        fork
            run_read(rd[7]);
            begin
                @(negedge clk); #1;
                IN_we = 1'b0;
                chk("rw_pwe", {OUT_pWe, OUT_werr}, {2'b01, 1'b0});
                chk("rw_fields", {OUT_pWmask, OUT_pWaddr, OUT_pWdata},
                    {4'b0001, 30'h3FC00001, 32'h00000055});
            end
        join

        // Slot 1 raises a stray valid while slot 0's read is in WAIT.
        v = '{32'hFF000000, 1, 0, 0, 3, 32'h0BADF00D, 32'h0BADF00D, 0, 1, 5, 1};
        @(negedge clk); #1;
        fork
            run_read(v);
            begin
                repeat (2) @(negedge clk);
                #1;
                pv_inj = 2'b10; pd_inj[63:32] = 32'hBAD0BAD0;
                @(negedge clk); #1;
                pv_inj = '0; pd_inj = '0;
            end
        join

        // Reset while a silent slot holds the read in WAIT.
        cfg_resp[0] = 1'b0; cfg_busy[0] = 0;
        @(negedge clk); #1;
        IN_re = 1'b1; IN_raddr = 30'h3FC00000;
        @(negedge clk); #1;
        IN_re = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("wait_busy", {OUT_rbusy, OUT_rvalid, OUT_pRe}, {1'b1, 1'b0, 2'b00});
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midrst_ctrl", {OUT_rbusy, OUT_rvalid, OUT_rerr, OUT_pRe}, 64'd0);
        chk("midrst_rdata", OUT_rdata, 64'd0);
        rst = 1'b0;
        v = '{32'hFF000008, 1, 0, 0, 1, 32'h00C0FFEE, 32'h00C0FFEE, 0, 1, 3, 1};
        run_read(v);
        repeat (2) @(negedge clk);
        #1;
        chk("rdata_hold", {OUT_rerr, OUT_rdata}, {1'b0, 32'h00C0FFEE});

`ifdef MMIO_ROUTER_TIMEOUT_EN
        v = '{32'h11000000, 1, 1, 0, 1, 32'h0, 32'h0, 1, 0, 17, 1};
        @(negedge clk); #1;
        run_read(v);
        @(negedge clk); #1;
        pv_inj = 2'b10; pd_inj[63:32] = 32'h77777777;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            pv_inj = '0; pd_inj = '0;
            if (OUT_rvalid || OUT_rbusy) cnt++;
        end
        chk("late_valid_ignored", 64'(cnt), 64'd0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
